// File: rtl/oam_dma.sv
// oam_dma: sprite DMA that halts the CPU and copies one 256-byte page into PPU OAM
// with 2A03 timing (513 CPU cycles, 514 when an extra alignment cycle is needed).
module oam_dma #(
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter int          XFER_LEN = 256
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CPU_CE,
    input  logic [15:0] ADDR,
    input  logic        CPU_WR,
    input  logic [7:0]  CPU_DO,
    input  logic [7:0]  BUS_IN,
    output logic        DMA,
    output logic [15:0] DMA_ADDR,
    output logic        CPU_HALT,
    output logic [7:0]  OAM_ADDR,
    output logic [7:0]  OAM_DATA,
    output logic        OAM_WE
);
    localparam logic [7:0] LAST = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_e;

    state_e      state_q;
    logic        parity_q;
    logic [7:0]  page_q;
    logic [7:0]  index_q;
    logic [7:0]  latch_q;
    logic        dma_q;
    logic        halt_q;
    logic [15:0] dma_addr_q;
    logic [7:0]  oam_addr_q;
    logic        oam_we_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            parity_q   <= 1'b0;
            page_q     <= 8'h00;
            index_q    <= 8'h00;
            latch_q    <= 8'h00;
            dma_q      <= 1'b0;
            halt_q     <= 1'b0;
            dma_addr_q <= 16'h0000;
            oam_addr_q <= 8'h00;
            oam_we_q   <= 1'b0;
        end else begin
            // the write strobe lives for exactly one Clk, even when CPU_CE is sparse
            oam_we_q <= 1'b0;
            if (CPU_CE) begin
                parity_q <= ~parity_q;
                case (state_q)
                    IDLE: if (ADDR == DMA_REG && !CPU_WR) begin
                        page_q     <= CPU_DO;
                        index_q    <= 8'h00;
                        dma_addr_q <= {CPU_DO, 8'h00};
                        dma_q      <= 1'b1;
                        halt_q     <= 1'b1;
                        state_q    <= HALT;
                    end
                    HALT:  state_q <= parity_q ? READ : ALIGN;
                    ALIGN: state_q <= READ;
                    READ: begin
                        latch_q    <= BUS_IN;
                        oam_addr_q <= index_q;
                        oam_we_q   <= 1'b1;
                        state_q    <= WRITE;
                    end
                    WRITE: begin
                        index_q <= index_q + 8'd1;
                        if (index_q == LAST) begin
                            dma_q   <= 1'b0;
                            halt_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            dma_addr_q <= {page_q, index_q + 8'd1};
                            state_q    <= READ;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign DMA      = dma_q;
    assign CPU_HALT = halt_q;
    assign DMA_ADDR = dma_addr_q;
    assign OAM_ADDR = oam_addr_q;
    assign OAM_DATA = latch_q;
    assign OAM_WE   = oam_we_q;
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed checks of oam_dma timing, data path, reset and CE gating.
module tb_oam_dma;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        CPU_CE = 1'b1;
    logic [15:0] ADDR = 16'h0000;
    logic        CPU_WR = 1'b1;
    logic [7:0]  CPU_DO = 8'h00;
    logic [7:0]  BUS_IN;
    logic        DMA, CPU_HALT, OAM_WE;
    logic [15:0] DMA_ADDR;
    logic [7:0]  OAM_ADDR, OAM_DATA;

    int n_vec = 0, n_bad = 0, ce_edges = 0;
    int halted, wes, first_we, first_oa, exp_idx, data_bad, addr_bad, frz_bad;
    logic done;
    logic [7:0] cur_page;

    oam_dma dut (
        .Clk(Clk), .Reset(Reset), .CPU_CE(CPU_CE), .ADDR(ADDR), .CPU_WR(CPU_WR),
        .CPU_DO(CPU_DO), .BUS_IN(BUS_IN), .DMA(DMA), .DMA_ADDR(DMA_ADDR),
        .CPU_HALT(CPU_HALT), .OAM_ADDR(OAM_ADDR), .OAM_DATA(OAM_DATA), .OAM_WE(OAM_WE)
    );

    always #5 Clk = ~Clk;

    // model memory: byte at {page,i} is i ^ 8'h5A
    assign BUS_IN = DMA_ADDR[7:0] ^ 8'h5A;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        if (CPU_CE && !Reset) ce_edges++;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        ce_edges = 0;
    endtask

    task automatic record(input int t);
        if (CPU_HALT) halted++;
        if (DMA && DMA_ADDR[15:8] != cur_page) addr_bad++;
        if (OAM_WE) begin
            wes++;
            if (first_we < 0) begin
                first_we = t;
                first_oa = OAM_ADDR;
            end
            if (OAM_ADDR != exp_idx[7:0]) data_bad++;
            if (OAM_DATA != (OAM_ADDR ^ 8'h5A)) data_bad++;
            if (DMA_ADDR != {cur_page, OAM_ADDR}) addr_bad++;
            exp_idx++;
        end
    endtask

    task automatic trigger(input logic [7:0] page, input int par);
        cur_page = page;
        halted = 0; wes = 0; first_we = -1; first_oa = -1; exp_idx = 0;
        data_bad = 0; addr_bad = 0; frz_bad = 0; done = 1'b0;
        while (ce_edges % 2 != par) tick();
        ADDR = 16'h4014; CPU_WR = 1'b0; CPU_DO = page;
        tick();
        ADDR = 16'h0000; CPU_WR = 1'b1;
        record(0);
    endtask

    task automatic run_xfer(input logic [7:0] page, input int par, input int inject_at,
                            input int freeze_at);
        logic [33:0] snap;
        trigger(page, par);
        for (int t = 1; t < 700; t++) begin
            if (!DMA) begin
                done = 1'b1;
                break;
            end
            if (t == inject_at) begin
                ADDR = 16'h4014; CPU_WR = 1'b0; CPU_DO = 8'h77;
            end
            tick();
            ADDR = 16'h0000; CPU_WR = 1'b1;
            record(t);
            if (t == freeze_at) begin
                snap = {DMA, CPU_HALT, DMA_ADDR, OAM_ADDR, OAM_DATA};
                CPU_CE = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    if ({DMA, CPU_HALT, DMA_ADDR, OAM_ADDR, OAM_DATA} != snap || OAM_WE)
                        frz_bad++;
                end
                CPU_CE = 1'b1;
            end
        end
    endtask

    task automatic xfer_chk(input string p, input logic [7:0] page, input int exp_halt,
                            input int exp_first);
        chk({p, ".done"}, 32'(done), 32'd1);
        chk({p, ".halted"}, halted, exp_halt);
        chk({p, ".we_pulses"}, wes, 256);
        chk({p, ".first_we_cycle"}, first_we, exp_first);
        chk({p, ".first_oam_addr"}, first_oa, 0);
        chk({p, ".data"}, data_bad, 0);
        chk({p, ".addr"}, addr_bad, 0);
        chk({p, ".halt_end"}, 32'(CPU_HALT), 32'd0);
        chk({p, ".last_dma_addr"}, 32'(DMA_ADDR), 32'({page, 8'hFF}));
        chk({p, ".last_oam_addr"}, 32'(OAM_ADDR), 32'hFF);
    endtask

    initial begin
        int idle_bad, found;
        do_reset();
        idle_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (DMA || CPU_HALT || OAM_WE || DMA_ADDR != 16'h0) idle_bad++;
        end
        chk("idle.any", idle_bad, 0);
        chk("idle.dma", 32'(DMA), 32'd0);
        chk("idle.dma_addr", 32'(DMA_ADDR), 32'd0);
        chk("idle.oam_addr", 32'(OAM_ADDR), 32'd0);
        chk("idle.oam_data", 32'(OAM_DATA), 32'd0);

        // a read of $4014 and a write to $4015 must not start anything
        ADDR = 16'h4014; CPU_WR = 1'b1; CPU_DO = 8'h02;
        tick();
        ADDR = 16'h4015; CPU_WR = 1'b0;
        tick();
        ADDR = 16'h0000; CPU_WR = 1'b1;
        tick(); tick();
        chk("nontrig.dma", 32'(DMA), 32'd0);
        chk("nontrig.halt", 32'(CPU_HALT), 32'd0);

        run_xfer(8'h02, 0, 0, 0);
        xfer_chk("even", 8'h02, 513, 2);
        run_xfer(8'h02, 1, 0, 0);
        xfer_chk("odd", 8'h02, 514, 3);
        run_xfer(8'hFF, 0, 0, 0);
        xfer_chk("rom", 8'hFF, 513, 2);

        trigger(8'h02, 0);
        found = 0;
        for (int t = 1; t < 300 && found == 0; t++) begin
            tick();
            if (OAM_WE && OAM_ADDR == 8'h40) found = 1;
        end
        chk("mid.found", found, 1);
        Reset = 1'b1;
        #1;
        chk("mid.outs", 32'({DMA, CPU_HALT, OAM_WE}), 32'd0);
        chk("mid.dma_addr", 32'(DMA_ADDR), 32'd0);
        chk("mid.oam", 32'({OAM_ADDR, OAM_DATA}), 32'd0);
        tick();
        Reset = 1'b0;
        ce_edges = 0;
        run_xfer(8'h03, 0, 0, 0);
        xfer_chk("restart", 8'h03, 513, 2);

        run_xfer(8'h02, 0, 50, 100);
        xfer_chk("inj_frz", 8'h02, 513, 2);
        chk("inj_frz.freeze", frz_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
